// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction-sequencing controller: FSM states,
// opcode/op encodings, one-hot write-back selects and IR field positions.
package ctrl_pkg;

  // StHalt is only reachable when CTRL_ILLEGAL_TRAP_EN is defined.
  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StWriteImm,
    StGetA,
    StGetB,
    StAlu,
    StWriteReg,
    StHalt
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [3:0] VSEL_MDATA = 4'b1000;
  localparam logic [3:0] VSEL_IMM   = 4'b0100;
  localparam logic [3:0] VSEL_PC    = 4'b0010;
  localparam logic [3:0] VSEL_C     = 4'b0001;

  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 13;
  localparam int unsigned OP_MSB   = 12;
  localparam int unsigned OP_LSB   = 11;
  localparam int unsigned RN_MSB   = 10;
  localparam int unsigned RN_LSB   = 8;
  localparam int unsigned RD_MSB   = 7;
  localparam int unsigned RD_LSB   = 5;
  localparam int unsigned SH_MSB   = 4;
  localparam int unsigned SH_LSB   = 3;
  localparam int unsigned RM_MSB   = 2;
  localparam int unsigned RM_LSB   = 0;
  localparam int unsigned IMM8_MSB = 7;
  localparam int unsigned IMM5_MSB = 4;

endpackage

// File: rtl/instr_dec.sv
// Combinational IR field extraction and immediate sign extension.
module instr_dec
  import ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o
);

  assign opcode_o = ir_i[OPC_MSB:OPC_LSB];
  assign op_o     = ir_i[OP_MSB:OP_LSB];
  assign rn_o     = ir_i[RN_MSB:RN_LSB];
  assign rd_o     = ir_i[RD_MSB:RD_LSB];
  assign sh_o     = ir_i[SH_MSB:SH_LSB];
  assign rm_o     = ir_i[RM_MSB:RM_LSB];

  assign sximm8_o = {{8{ir_i[IMM8_MSB]}}, ir_i[IMM8_MSB:0]};
  assign sximm5_o = {{11{ir_i[IMM5_MSB]}}, ir_i[IMM5_MSB:0]};

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Instruction-sequencing controller driving the datapath control inputs.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap illegal encodings in
// a HALT state (exposes the `illegal` port); otherwise they fall back to WAIT.
module cpu_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [3:0]  vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic [15:0] sximm5
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        write_raw;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;

  instr_dec u_instr_dec (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .op_o     (op),
    .rn_o     (rn),
    .rd_o     (rd),
    .sh_o     (shift),
    .rm_o     (rm),
    .sximm5_o (sximm5),
    .sximm8_o (sximm8)
  );

  logic is_mov, is_alu, is_mov_imm, is_mov_reg, is_mvn, is_cmp;
  assign is_mov     = (opcode == OPC_MOV);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_mov_imm = is_mov && (op == OP_MOV_IMM);
  assign is_mov_reg = is_mov && (op == OP_MOV_REG);
  assign is_mvn     = is_alu && (op == OP_MVN);
  assign is_cmp     = is_alu && (op == OP_CMP);

  // State and instruction register, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic; IR only loads on an accepted start in WAIT.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StWait: begin
        if (s) begin
          ir_d    = in;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (is_mov_imm) begin
          state_d = StWriteImm;
        end else if (is_mov_reg || is_mvn) begin
          state_d = StGetB;
        end else if (is_alu) begin
          state_d = StGetA;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = StHalt;
`else
          state_d = StWait;
`endif
        end
      end
      StWriteImm: state_d = StWait;
      StGetA:     state_d = StGetB;
      StGetB:     state_d = StAlu;
      StAlu:      state_d = is_cmp ? StWait : StWriteReg;
      StWriteReg: state_d = StWait;
`ifdef CTRL_ILLEGAL_TRAP_EN
      StHalt:     state_d = StHalt;
`endif
      default:    state_d = StWait;
    endcase
  end

  // Moore outputs decoded from state and IR fields.
  always_comb begin
    w         = 1'b0;
    readnum   = 3'd0;
    writenum  = 3'd0;
    vsel      = 4'b0000;
    write_raw = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    ALUop     = 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal   = 1'b0;
`endif
    unique case (state_q)
      StWait: w = 1'b1;
      StWriteImm: begin
        writenum  = rn;
        vsel      = VSEL_IMM;
        write_raw = 1'b1;
      end
      StGetA: begin
        readnum = rn;
        loada   = 1'b1;
      end
      StGetB: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      StAlu: begin
        // MOV reg and MVN pass B through the ALU with A zeroed.
        asel  = is_mov_reg || is_mvn;
        ALUop = is_mov_reg ? 2'b00 : op;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      StWriteReg: begin
        writenum  = rd;
        vsel      = VSEL_C;
        write_raw = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      StHalt: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  // Reset must suppress a register-file write even if it lands in a write state.
  assign write = write_raw & ~reset;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed instructions with
// hand-computed per-cycle expectations. Build with CTRL_ILLEGAL_TRAP_EN to
// exercise the HALT trap.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;

  cpu_ctrl_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .in       (in),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .vsel     (vsel),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal  (illegal),
`endif
    .sximm5   (sximm5)
  );

  always #5 clk = ~clk;

  // {write, loada, loadb, loadc, loads, asel, bsel}
  logic [6:0] strobes;
  assign strobes = {write, loada, loadb, loadc, loads, asel, bsel};

  // Present an instruction at a WAIT negedge and let the accepting edge pass.
  task automatic issue(input logic [15:0] instr);
    in = instr;
    s  = 1'b1;
    @(posedge clk);
    #1;
    s  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s     = 1'b0;
    in    = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL reset_w got %b want 1", w);
    end
    checks++;
    if ({strobes, vsel, readnum, writenum, shift, ALUop, sximm8, sximm5} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got strobes=%b vsel=%b rn=%0d wn=%0d sh=%b op=%b i8=%h i5=%h want all 0",
               strobes, vsel, readnum, writenum, shift, ALUop, sximm8, sximm5);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal got %b want 0", illegal);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mov_imm();
    issue(16'hD108);
    @(negedge clk);  // DECODE
    checks++;
    if (w !== 1'b0 || strobes !== 7'b0) begin
      errors++;
      $display("FAIL movimm_decode got w=%b strobes=%b want 0/0", w, strobes);
    end
    @(negedge clk);  // WRITE_IMM
    checks++;
    if (write !== 1'b1 || writenum !== 3'd1 || vsel !== 4'b0100 || sximm8 !== 16'h0008) begin
      errors++;
      $display("FAIL movimm_write got write=%b wn=%0d vsel=%b i8=%h want 1/1/0100/0008",
               write, writenum, vsel, sximm8);
    end
    @(negedge clk);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL movimm_latency got w=%b want 1 after 2 cycles", w);
    end
  endtask

  task automatic test_add();
    issue(16'hA148);
    @(negedge clk);  // DECODE
    @(negedge clk);  // GET_A
    checks++;
    if (readnum !== 3'd1 || loada !== 1'b1 || loadb !== 1'b0) begin
      errors++;
      $display("FAIL add_geta got rn=%0d loada=%b loadb=%b want 1/1/0", readnum, loada, loadb);
    end
    @(negedge clk);  // GET_B
    checks++;
    if (readnum !== 3'd0 || loadb !== 1'b1 || loada !== 1'b0) begin
      errors++;
      $display("FAIL add_getb got rn=%0d loadb=%b loada=%b want 0/1/0", readnum, loadb, loada);
    end
    @(negedge clk);  // ALU
    checks++;
    if (ALUop !== 2'b00 || shift !== 2'b01 || loadc !== 1'b1 || loads !== 1'b0 ||
        asel !== 1'b0 || bsel !== 1'b0) begin
      errors++;
      $display("FAIL add_alu got op=%b sh=%b loadc=%b loads=%b asel=%b bsel=%b want 00/01/1/0/0/0",
               ALUop, shift, loadc, loads, asel, bsel);
    end
    @(negedge clk);  // WRITE_REG
    checks++;
    if (writenum !== 3'd2 || vsel !== 4'b0001 || write !== 1'b1) begin
      errors++;
      $display("FAIL add_wb got wn=%0d vsel=%b write=%b want 2/0001/1", writenum, vsel, write);
    end
    @(negedge clk);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL add_latency got w=%b want 1 after 5 cycles", w);
    end
  endtask

  task automatic test_cmp();
    logic saw_write = 1'b0;
    issue(16'hA900);
    for (int i = 0; i < 3; i++) begin  // DECODE, GET_A, GET_B
      @(negedge clk);
      saw_write |= write;
    end
    @(negedge clk);  // ALU
    saw_write |= write;
    checks++;
    if (loads !== 1'b1 || loadc !== 1'b0 || ALUop !== 2'b01) begin
      errors++;
      $display("FAIL cmp_alu got loads=%b loadc=%b op=%b want 1/0/01", loads, loadc, ALUop);
    end
    @(negedge clk);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL cmp_latency got w=%b want 1 after 4 cycles", w);
    end
    checks++;
    if (saw_write !== 1'b0) begin
      errors++;
      $display("FAIL cmp_nowrite got write seen=%b want 0", saw_write);
    end
  endtask

  task automatic test_mvn();
    issue(16'hB861);
    @(negedge clk);  // DECODE
    @(negedge clk);  // must be GET_B directly
    checks++;
    if (loada !== 1'b0 || loadb !== 1'b1 || readnum !== 3'd1) begin
      errors++;
      $display("FAIL mvn_getb got loada=%b loadb=%b rn=%0d want 0/1/1", loada, loadb, readnum);
    end
    @(negedge clk);  // ALU
    checks++;
    if (asel !== 1'b1 || ALUop !== 2'b11 || loadc !== 1'b1) begin
      errors++;
      $display("FAIL mvn_alu got asel=%b op=%b loadc=%b want 1/11/1", asel, ALUop, loadc);
    end
    @(negedge clk);  // WRITE_REG
    checks++;
    if (writenum !== 3'd3 || write !== 1'b1 || vsel !== 4'b0001) begin
      errors++;
      $display("FAIL mvn_wb got wn=%0d write=%b vsel=%b want 3/1/0001", writenum, write, vsel);
    end
    @(negedge clk);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL mvn_latency got w=%b want 1 after 4 cycles", w);
    end
  endtask

  // MOV R5, R2: 110_00_000_101_00_010
  task automatic test_mov_reg();
    issue(16'hC0A2);
    @(negedge clk);  // DECODE
    checks++;
    if (sximm5 !== 16'h0002) begin
      errors++;
      $display("FAIL movreg_sximm5 got %h want 0002", sximm5);
    end
    @(negedge clk);  // GET_B
    checks++;
    if (readnum !== 3'd2 || loadb !== 1'b1 || loada !== 1'b0) begin
      errors++;
      $display("FAIL movreg_getb got rn=%0d loadb=%b loada=%b want 2/1/0", readnum, loadb, loada);
    end
    @(negedge clk);  // ALU
    checks++;
    if (asel !== 1'b1 || ALUop !== 2'b00 || loadc !== 1'b1 || loads !== 1'b0) begin
      errors++;
      $display("FAIL movreg_alu got asel=%b op=%b loadc=%b loads=%b want 1/00/1/0",
               asel, ALUop, loadc, loads);
    end
    @(negedge clk);  // WRITE_REG
    checks++;
    if (writenum !== 3'd5 || write !== 1'b1) begin
      errors++;
      $display("FAIL movreg_wb got wn=%0d write=%b want 5/1", writenum, write);
    end
    @(negedge clk);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL movreg_latency got w=%b want 1 after 4 cycles", w);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_write = 1'b0;
    issue(16'hA148);
    for (int i = 0; i < 3; i++) begin  // DECODE, GET_A, GET_B
      @(negedge clk);
      saw_write |= write;
    end
    reset = 1'b1;  // asserted during GET_B
    @(negedge clk);
    saw_write |= write;
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wait got w=%b want 1", w);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_write |= write;
    end
    checks++;
    if (saw_write !== 1'b0 || w !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_nowrite got write seen=%b w=%b want 0/1", saw_write, w);
    end
  endtask

  // s held high: MOV R1,#-16 then MOV R2,#3 with one WAIT cycle between;
  // `in` changes mid-instruction to show the IR holds its value.
  task automatic test_back_to_back();
    in = 16'hD1F0;
    s  = 1'b1;
    @(posedge clk);
    #1;
    in = 16'hD203;
    @(negedge clk);  // DECODE of D1F0
    checks++;
    if (sximm8 !== 16'hFFF0 || sximm5 !== 16'hFFF0) begin
      errors++;
      $display("FAIL b2b_ir_stable got i8=%h i5=%h want FFF0/FFF0", sximm8, sximm5);
    end
    @(negedge clk);  // WRITE_IMM
    checks++;
    if (writenum !== 3'd1 || write !== 1'b1 || sximm8 !== 16'hFFF0) begin
      errors++;
      $display("FAIL b2b_first_wb got wn=%0d write=%b i8=%h want 1/1/FFF0", writenum, write, sximm8);
    end
    @(negedge clk);  // single WAIT
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wait got w=%b want 1", w);
    end
    @(negedge clk);  // DECODE of D203
    checks++;
    if (w !== 1'b0 || sximm8 !== 16'h0003) begin
      errors++;
      $display("FAIL b2b_second_decode got w=%b i8=%h want 0/0003", w, sximm8);
    end
    s = 1'b0;
    @(negedge clk);  // WRITE_IMM
    checks++;
    if (writenum !== 3'd2 || write !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_wb got wn=%0d write=%b want 2/1", writenum, write);
    end
    @(negedge clk);
    checks++;
    if (w !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got w=%b want 1", w);
    end
  endtask

  task automatic test_illegal();
    issue(16'h0000);
    @(negedge clk);  // DECODE
    checks++;
    if (strobes !== 7'b0 || w !== 1'b0) begin
      errors++;
      $display("FAIL illegal_decode got strobes=%b w=%b want 0/0", strobes, w);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    s = 1'b1;  // must not restart from HALT
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (illegal !== 1'b1 || w !== 1'b0 || strobes !== 7'b0) begin
        errors++;
        $display("FAIL illegal_halt cycle %0d got illegal=%b w=%b strobes=%b want 1/0/0",
                 i, illegal, w, strobes);
      end
    end
    s     = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || w !== 1'b1) begin
      errors++;
      $display("FAIL illegal_exit got illegal=%b w=%b want 0/1", illegal, w);
    end
`else
    @(negedge clk);
    checks++;
    if (w !== 1'b1 || strobes !== 7'b0) begin
      errors++;
      $display("FAIL illegal_return got w=%b strobes=%b want 1/0", w, strobes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn();
    test_mov_reg();
    test_reset_mid();
    test_back_to_back();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
